// File: rtl/samples_mem_pkg.sv
// Shared definitions for the sample-memory upload/download paths.
package samples_mem_pkg;

  localparam int IOCTL_ADDR_W = 25;
  localparam logic [7:0] OOR_FILL_DEFAULT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE,
    READY,
    REQ,
    CAPTURE
  } upload_state_t;

endpackage

// File: rtl/samples_mem_upload.sv
// HPS upload reader: serves ioctl byte reads from the sample RAM through a
// request/grant borrowed read port, tracking byte count and checksum.
module samples_mem_upload
  import samples_mem_pkg::*;
#(
  parameter int         ADDR_WIDTH = 13,
  parameter int         DATA_WIDTH = 8,
  parameter logic [7:0] OOR_FILL   = OOR_FILL_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ioctl_upload,
  input  logic                    ioctl_rd,
  input  logic [IOCTL_ADDR_W-1:0] ioctl_addr,
  output logic [7:0]              ioctl_din,
  output logic                    ioctl_wait,
  output logic                    mem_req,
  input  logic                    mem_gnt,
  output logic                    mem_rd,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  input  logic [DATA_WIDTH-1:0]   mem_data,
  output logic                    upload_active,
  output logic [ADDR_WIDTH:0]     byte_count,
  output logic [7:0]              checksum,
  output logic                    protocol_err
);

  localparam logic [ADDR_WIDTH:0] CNT_ONE = 1;

  upload_state_t r_state;
  upload_state_t w_next;

  logic [7:0]            r_din;
  logic                  r_wait;
  logic                  r_mem_req;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic                  r_upload_active;
  logic [ADDR_WIDTH:0]   r_byte_count;
  logic [7:0]            r_checksum;
  logic                  r_protocol_err;

  logic       w_in_range;
  logic       w_abort;
  logic       w_serve;
  logic [7:0] w_serve_byte;

  // Upper address bits are compared so out-of-range reads never alias.
  assign w_in_range = (ioctl_addr[IOCTL_ADDR_W-1:ADDR_WIDTH] == '0);
  assign w_abort    = (r_state != IDLE) && !ioctl_upload;

  always_comb begin
    w_serve      = 1'b0;
    w_serve_byte = 8'h00;
    if (!w_abort) begin
      if (r_state == CAPTURE) begin
        w_serve      = 1'b1;
        w_serve_byte = mem_data[7:0];
      end else if (r_state == READY && ioctl_rd && !w_in_range) begin
        w_serve      = 1'b1;
        w_serve_byte = OOR_FILL;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (ioctl_upload) w_next = READY;
      READY:   if (!ioctl_upload) w_next = IDLE;
               else if (ioctl_rd && w_in_range) w_next = REQ;
      REQ:     if (!ioctl_upload) w_next = IDLE;
               else if (mem_gnt) w_next = CAPTURE;
      CAPTURE: if (!ioctl_upload) w_next = IDLE;
               else w_next = READY;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_din           <= '0;
      r_wait          <= 1'b0;
      r_mem_req       <= 1'b0;
      r_mem_addr      <= '0;
      r_upload_active <= 1'b0;
      r_byte_count    <= '0;
      r_checksum      <= '0;
      r_protocol_err  <= 1'b0;
    end else begin
      r_upload_active <= ioctl_upload;

      if (w_serve) begin
        r_din      <= w_serve_byte;
        r_checksum <= r_checksum + w_serve_byte;
        if (r_byte_count != '1) r_byte_count <= r_byte_count + CNT_ONE;
      end

      // An abort drops the handshake but keeps the session results visible.
      if (w_abort) begin
        r_mem_req <= 1'b0;
        r_wait    <= 1'b0;
      end else begin
        unique case (r_state)
          IDLE: begin
            if (ioctl_upload) begin
              r_byte_count   <= '0;
              r_checksum     <= '0;
              r_protocol_err <= 1'b0;
            end
          end
          READY: begin
            if (ioctl_rd && w_in_range) begin
              r_mem_addr <= ioctl_addr[ADDR_WIDTH-1:0];
              r_wait     <= 1'b1;
              r_mem_req  <= 1'b1;
            end
          end
          REQ: begin
            if (mem_gnt)  r_mem_req      <= 1'b0;
            if (ioctl_rd) r_protocol_err <= 1'b1;
          end
          CAPTURE: begin
            r_wait <= 1'b0;
            if (ioctl_rd) r_protocol_err <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign mem_rd        = (r_state == REQ) && mem_gnt;
  assign ioctl_din     = r_din;
  assign ioctl_wait    = r_wait;
  assign mem_req       = r_mem_req;
  assign mem_addr      = r_mem_addr;
  assign upload_active = r_upload_active;
  assign byte_count    = r_byte_count;
  assign checksum      = r_checksum;
  assign protocol_err  = r_protocol_err;

endmodule

// File: tb/tb_samples_mem_upload.sv
// Directed bench for samples_mem_upload with a one-cycle-latency memory model.
module tb_samples_mem_upload;

  logic        clk;
  logic        reset;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic        mem_req;
  logic        mem_gnt;
  logic        mem_rd;
  logic [12:0] mem_addr;
  logic [7:0]  mem_data;
  logic        upload_active;
  logic [13:0] byte_count;
  logic [7:0]  checksum;
  logic        protocol_err;

  int nAsserts = 0;
  int nFails   = 0;
  int rdPulses = 0;

  logic [7:0] memArr [0:8191];

  samples_mem_upload #(
    .ADDR_WIDTH(13),
    .DATA_WIDTH(8),
    .OOR_FILL(8'hFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .ioctl_upload(ioctl_upload),
    .ioctl_rd(ioctl_rd),
    .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din),
    .ioctl_wait(ioctl_wait),
    .mem_req(mem_req),
    .mem_gnt(mem_gnt),
    .mem_rd(mem_rd),
    .mem_addr(mem_addr),
    .mem_data(mem_data),
    .upload_active(upload_active),
    .byte_count(byte_count),
    .checksum(checksum),
    .protocol_err(protocol_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous-read sample RAM: data appears one cycle after mem_rd.
  always @(posedge clk) begin
    if (mem_rd) mem_data <= memArr[mem_addr];
    if (mem_rd) rdPulses <= rdPulses + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected)
    else begin
      nFails++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drives one strobe, then counts sampled cycles with ioctl_wait high.
  task automatic applyStimulus(input logic [24:0] addr, output int waitCycles);
    ioctl_rd   = 1'b1;
    ioctl_addr = addr;
    tick();
    ioctl_rd   = 1'b0;
    waitCycles = 0;
    while (ioctl_wait === 1'b1 && waitCycles < 50) begin
      waitCycles++;
      tick();
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_din"},   32'(ioctl_din), 32'h0);
    checkOutput({tag, "_wait"},  32'(ioctl_wait), 32'h0);
    checkOutput({tag, "_req"},   32'(mem_req), 32'h0);
    checkOutput({tag, "_addr"},  32'(mem_addr), 32'h0);
    checkOutput({tag, "_act"},   32'(upload_active), 32'h0);
    checkOutput({tag, "_count"}, 32'(byte_count), 32'h0);
    checkOutput({tag, "_csum"},  32'(checksum), 32'h0);
    checkOutput({tag, "_perr"},  32'(protocol_err), 32'h0);
  endtask

  initial begin
    int n;
    int pulsesBefore;
    logic [7:0] expData [0:3];

    for (int i = 0; i < 8192; i++) memArr[i] = 8'h00;
    memArr[0] = 8'h12; memArr[1] = 8'h34; memArr[2] = 8'h56; memArr[3] = 8'h78;
    expData[0] = 8'h12; expData[1] = 8'h34; expData[2] = 8'h56; expData[3] = 8'h78;

    reset        = 1'b1;
    ioctl_upload = 1'b0;
    ioctl_rd     = 1'b0;
    ioctl_addr   = '0;
    mem_gnt      = 1'b0;
    #3;
    checkAllZero("reset");
    checkOutput("reset_memrd", 32'(mem_rd), 32'h0);
    tick();
    tick();
    reset = 1'b0;

    // Session start with grant held high
    mem_gnt      = 1'b1;
    ioctl_upload = 1'b1;
    tick();
    checkOutput("upload_active", 32'(upload_active), 32'h1);

    for (int a = 0; a < 4; a++) begin
      applyStimulus(25'(a), n);
      checkOutput($sformatf("rd%0d_wait", a), 32'(n), 32'd2);
      checkOutput($sformatf("rd%0d_din", a), 32'(ioctl_din), 32'(expData[a]));
    end
    checkOutput("seq_count", 32'(byte_count), 32'd4);
    checkOutput("seq_csum",  32'(checksum), 32'h14);

    // Grant delayed by 5 cycles on address 1
    mem_gnt      = 1'b0;
    pulsesBefore = rdPulses;
    ioctl_rd     = 1'b1;
    ioctl_addr   = 25'd1;
    tick();
    ioctl_rd = 1'b0;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (ioctl_wait === 1'b1) n++;
      tick();
    end
    checkOutput("dly_req_held", 32'(mem_req), 32'h1);
    checkOutput("dly_memrd_low", 32'(mem_rd), 32'h0);
    mem_gnt = 1'b1;
    while (ioctl_wait === 1'b1 && n < 50) begin
      n++;
      tick();
    end
    checkOutput("dly_wait", 32'(n), 32'd7);
    checkOutput("dly_pulses", 32'(rdPulses - pulsesBefore), 32'd1);
    checkOutput("dly_din", 32'(ioctl_din), 32'h34);
    checkOutput("dly_count", 32'(byte_count), 32'd5);
    checkOutput("dly_csum", 32'(checksum), 32'h48);

    // Out-of-range read just above the 13-bit window
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'h2000;
    tick();
    ioctl_rd = 1'b0;
    checkOutput("oor_din",  32'(ioctl_din), 32'hFF);
    checkOutput("oor_wait", 32'(ioctl_wait), 32'h0);
    checkOutput("oor_req",  32'(mem_req), 32'h0);
    tick();
    checkOutput("oor_wait2", 32'(ioctl_wait), 32'h0);
    checkOutput("oor_count", 32'(byte_count), 32'd6);
    checkOutput("oor_csum",  32'(checksum), 32'h47);

    // Second strobe while the fetch waits in REQ
    mem_gnt    = 1'b0;
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'd2;
    tick();
    ioctl_addr = 25'd3;
    tick();
    ioctl_rd = 1'b0;
    checkOutput("perr_set",  32'(protocol_err), 32'h1);
    checkOutput("perr_wait", 32'(ioctl_wait), 32'h1);
    mem_gnt = 1'b1;
    n = 0;
    while (ioctl_wait === 1'b1 && n < 50) begin
      n++;
      tick();
    end
    checkOutput("perr_done", 32'(ioctl_wait), 32'h0);
    checkOutput("perr_din",   32'(ioctl_din), 32'h56);
    checkOutput("perr_count", 32'(byte_count), 32'd7);
    checkOutput("perr_csum",  32'(checksum), 32'h9D);

    // Abort during REQ; grant arrives on the abort edge
    mem_gnt    = 1'b0;
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'd0;
    tick();
    ioctl_rd = 1'b0;
    checkOutput("abort_req_pre", 32'(mem_req), 32'h1);
    ioctl_upload = 1'b0;
    mem_gnt      = 1'b1;
    tick();
    checkOutput("abort_req",   32'(mem_req), 32'h0);
    checkOutput("abort_wait",  32'(ioctl_wait), 32'h0);
    checkOutput("abort_din",   32'(ioctl_din), 32'h56);
    checkOutput("abort_count", 32'(byte_count), 32'd7);
    checkOutput("abort_csum",  32'(checksum), 32'h9D);
    checkOutput("abort_perr",  32'(protocol_err), 32'h1);
    tick();
    checkOutput("abort_idle_count", 32'(byte_count), 32'd7);
    ioctl_upload = 1'b1;
    tick();
    checkOutput("new_count", 32'(byte_count), 32'd0);
    checkOutput("new_csum",  32'(checksum), 32'h0);
    checkOutput("new_perr",  32'(protocol_err), 32'h0);

    // One read to populate outputs, then reset mid-CAPTURE
    applyStimulus(25'd3, n);
    checkOutput("pre_rst_din",   32'(ioctl_din), 32'h78);
    checkOutput("pre_rst_count", 32'(byte_count), 32'd1);
    ioctl_rd   = 1'b1;
    ioctl_addr = 25'd3;
    tick();
    ioctl_rd = 1'b0;
    tick();
    checkOutput("cap_wait", 32'(ioctl_wait), 32'h1);
    #2;
    reset = 1'b1;
    #1;
    checkAllZero("async_rst");
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/samples_mem_upload.md
# samples_mem_upload

Upload engine for the program sample RAM: the HPS-facing reader that serves MiSTer `ioctl` upload requests by fetching bytes from the sample memory and returning them on `ioctl_din`. It is the complement of the download path that fills the RAM. It sits between the `hps_io` upload signals and a shared memory read port, which it borrows through a request/grant handshake. It keeps a byte count and a running checksum for save-verification.

## Interface
- `ADDR_WIDTH`, 13: sample memory address width; the valid range is 0 to 2**ADDR_WIDTH-1.
- `DATA_WIDTH`, 8: memory word width; must be 8.
- `OOR_FILL`, 8'hFF: byte returned for out-of-range addresses.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `ioctl_upload`  in  1  upload session active (level).
- `ioctl_rd`  in  1  single-cycle byte read strobe from the HPS.
- `ioctl_addr`  in  25  byte address, valid with `ioctl_rd`.
- `ioctl_din`  out  8  registered read data to the HPS.
- `ioctl_wait`  out  1  registered; high while a fetch is outstanding.
- `mem_req`  out  1  registered request for the memory read port.
- `mem_gnt`  in  1  grant from the memory port owner.
- `mem_rd`  out  1  combinational read strobe, high = (state == REQ) && `mem_gnt`.
- `mem_addr`  out  ADDR_WIDTH  registered latched address.
- `mem_data`  in  DATA_WIDTH  memory read data, valid 1 cycle after `mem_rd`.
- `upload_active`  out  1  registered copy of `ioctl_upload`.
- `byte_count`  out  ADDR_WIDTH+1  bytes served this session; saturates at all-ones.
- `checksum`  out  8  mod-256 sum of bytes served this session.
- `protocol_err`  out  1  sticky flag, set when `ioctl_rd` arrives while busy.

## Operation
- Reset values: all outputs 0; state IDLE.
- States: IDLE, READY, REQ, CAPTURE.
- **IDLE**
  - `ioctl_upload` high moves to READY.
  - The same edge clears `byte_count`, `checksum` and `protocol_err`.
- **READY**, on `ioctl_rd`:
  - In range (`ioctl_addr` < 2**ADDR_WIDTH): latch the address into `mem_addr`, set `ioctl_wait` and `mem_req` to 1, go to REQ.
  - Out of range: no memory access. `ioctl_din` <= `OOR_FILL`, `ioctl_wait` stays 0, count and checksum update, stay in READY.
- **REQ**
  - Hold `mem_req` until `mem_gnt` is sampled high; the wait is unbounded.
  - On grant, `mem_rd` is high that cycle. Next state CAPTURE, and `mem_req` drops.
- **CAPTURE**
  - `ioctl_din` <= `mem_data[7:0]`; `ioctl_wait` <= 0.
  - `byte_count` += 1, saturating.
  - `checksum` += data, mod 256.
  - Return to READY.
- `ioctl_rd` in REQ or CAPTURE: ignored, and `protocol_err` is set. The in-flight fetch is unaffected.
- `ioctl_upload` low in any non-IDLE state: go to IDLE on the next edge.
  - `mem_req` and `ioctl_wait` go to 0.
  - `ioctl_din`, `byte_count`, `checksum` and `protocol_err` hold their values until the next session starts.
  - A grant arriving on the abort edge is ignored.
- Address aliasing is forbidden: upper `ioctl_addr` bits are compared, never truncated.

## Timing
- Edge numbering: the read starts at the rising edge that samples `ioctl_rd` high, called E0.
- In-range read, grant already high:
  - After E0: `ioctl_wait` = 1, state REQ.
  - `mem_rd` is high during the cycle after E0.
  - E1: the memory registers the data; state CAPTURE.
  - After E2: `ioctl_din` valid and `ioctl_wait` = 0. Total 2 cycles from the strobe edge.
- Each cycle of grant delay adds exactly 1 cycle.
- Out-of-range read: `ioctl_din` = `OOR_FILL` after E0; `ioctl_wait` is never raised.
- The HPS may issue the next `ioctl_rd` in the first cycle `ioctl_wait` is low.
- Reset is asynchronous at any point, including mid-fetch: all outputs clear immediately.

## Structure
- A shared package `samples_mem_pkg` holds:
  - the state enum `upload_state_t` (IDLE, READY, REQ, CAPTURE);
  - `OOR_FILL_DEFAULT`;
  - `IOCTL_ADDR_W` = 25.
- Single module with no sub-module. The checksum and count logic is inline; at 8-bit width it is trivial.

## Test plan
- Preload the memory with mem[0..3] = 12,34,56,78 and hold grant high. Read addresses 0..3 → `ioctl_din` sequence 12,34,56,78; each strobe gives `ioctl_wait` high for 2 cycles; `byte_count` = 4, `checksum` = 8'h14.
- Delay grant by 5 cycles on address 1 → `ioctl_wait` is high for 7 cycles; `mem_rd` pulses exactly once; `ioctl_din` = 34.
- With ADDR_WIDTH = 13, read address 25'h2000 → `ioctl_din` = FF the next cycle; `ioctl_wait` never rises; `mem_req` stays 0; `checksum` += FF.
- Issue a second `ioctl_rd` while in REQ → `protocol_err` = 1; one fetch completes; `byte_count` increments by 1.
- Drop `ioctl_upload` during REQ → after one edge, state IDLE with `mem_req` = 0 and `ioctl_wait` = 0. A new session clears `byte_count` and `checksum` to 0.
- Assert `reset` asynchronously mid-CAPTURE → all outputs read 0 before the next clock edge.
